// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the fifo_sc reader (prefetch buffer and credit logic).
package fifo_rd_pkg;

   localparam int MAX_BUF_DEPTH = 8;

   // Holds 0..MAX_BUF_DEPTH inclusive.
   typedef logic [3:0] occ_t;

   function automatic int clog2_min1(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Prefetch buffer: BUF_DEPTH x W register array with wrapping write/read pointers.
module fifo_rd_buf
   import fifo_rd_pkg::*;
#(
   parameter int W         = 16,
   parameter int BUF_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o
);

   localparam int PW = clog2_min1(BUF_DEPTH);
   localparam logic [PW-1:0] LAST_IDX = PW'(BUF_DEPTH - 1);

   logic [W-1:0]  mem_q [BUF_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == LAST_IDX) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wr_ptr_d = push_i ? wrap_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_i  ? wrap_inc(rd_ptr_q) : rd_ptr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset: the head word is only meaningful once occupancy is non-zero.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_sc_reader.sv
// Drains a one-cycle-latency FIFO into a valid/ready stream using credit-tracked prefetch.
// Optional packet framing on m_last is enabled by defining FIFO_RD_LAST_EN.
module fifo_sc_reader
   import fifo_rd_pkg::*;
#(
   parameter int W         = 16,
   parameter int BUF_DEPTH = 2,
   parameter int PKT_LEN   = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic         fifo_read,
   input  logic         fifo_empty,
   input  logic [W-1:0] fifo_data,
   input  logic         fifo_valid,
   output logic [W-1:0] m_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic         m_last,
   output logic         err
);

   localparam int   SPW  = $clog2(BUF_DEPTH) + 2;
   localparam occ_t FULL = occ_t'(BUF_DEPTH);

   occ_t           occ_q, occ_d;
   logic           inflight_q;
   logic           err_q, err_d;
   logic           pop, push, overflow;
   logic [SPW-1:0] space;

   assign m_valid = (occ_q != '0);
   assign pop     = m_valid & m_ready;

   // Credits: free slots not already promised to an in-flight read; a pop this cycle frees one.
   assign space     = SPW'(BUF_DEPTH) - SPW'(occ_q) - SPW'(inflight_q) + SPW'(pop);
   assign fifo_read = en & ~fifo_empty & (space != '0);

   assign overflow = fifo_valid & (occ_q == FULL) & ~pop;
   assign push     = fifo_valid & ~overflow;

   always_comb begin
      occ_d = occ_q;
      if (push & ~pop)      occ_d = occ_q + occ_t'(1);
      else if (~push & pop) occ_d = occ_q - occ_t'(1);
      err_d = err_q | (fifo_valid & ~inflight_q) | overflow;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q      <= '0;
         inflight_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= fifo_read;
         err_q      <= err_d;
      end
   end

   assign err = err_q;

   fifo_rd_buf #(
      .W         (W),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (fifo_data),
      .rdata_o (m_data)
   );

`ifdef FIFO_RD_LAST_EN
   localparam int CW = clog2_min1(PKT_LEN + 1);

   logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;

   assign m_last = (pkt_cnt_q == CW'(PKT_LEN - 1)) & m_valid;

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (pop) pkt_cnt_d = m_last ? '0 : pkt_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pkt_cnt_q <= '0;
      else     pkt_cnt_q <= pkt_cnt_d;
   end
`else
   assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sc_reader.sv
// Directed bench for fifo_sc_reader with a behavioural one-cycle-latency FIFO (8 entries) upstream.
module tb_fifo_sc_reader;

   localparam int W         = 16;
   localparam int BUF_DEPTH = 2;
   localparam int PKT_LEN   = 3;
   localparam int FIFO_CAP  = 8;
`ifdef FIFO_RD_LAST_EN
   localparam int EXP_LASTS = 2;
`else
   localparam int EXP_LASTS = 0;
`endif

   logic         clk = 1'b0;
   logic         rst, en, m_ready;
   logic         fifo_read, fifo_empty, fifo_valid;
   logic         m_valid, m_last, err;
   logic [W-1:0] fifo_data, m_data;

   // Upstream FIFO model state
   logic         fifo_rst, wr_en, spur, fv_q, fe_q, rd_acc;
   logic [W-1:0] wr_data, fd_q;
   logic [W-1:0] fq [$];

   int           checks = 0;
   int           failures = 0;
   logic [W-1:0] exp_q [$];
   int           cyc = 0;
   int           read_cnt = 0, beat_cnt = 0, last_cnt = 0, pkt_idx = 0;
   int           first_read = -1, first_valid = -1, first_beat = -1, last_beat = -1;
   logic         stalled_prev = 1'b0;
   logic [W-1:0] stall_data = '0;

   always #5 clk = ~clk;

   fifo_sc_reader #(
      .W         (W),
      .BUF_DEPTH (BUF_DEPTH),
      .PKT_LEN   (PKT_LEN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .fifo_read  (fifo_read),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_valid (fifo_valid),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .err        (err)
   );

   assign fifo_empty = fe_q;
   assign fifo_data  = fd_q;
   assign fifo_valid = fv_q | spur;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (fifo_rst) begin
         fq.delete();
         fv_q <= 1'b0;
         fd_q <= '0;
         fe_q <= 1'b1;
      end else begin
         rd_acc = fifo_read && (fq.size() != 0);
         if (rd_acc) fd_q <= fq.pop_front();
         fv_q <= rd_acc;
         if (wr_en && fq.size() < FIFO_CAP) fq.push_back(wr_data);
         fe_q <= (fq.size() == 0);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard and stream monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         stalled_prev = 1'b0;
      end else begin
         if (fifo_read) begin
            read_cnt++;
            if (first_read < 0) first_read = cyc;
         end
         if (m_valid && first_valid < 0) first_valid = cyc;
         if (stalled_prev) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, stall_data);
         end
         if (m_valid && m_ready) begin
            beat_cnt++;
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
            if (exp_q.size() == 0) check("beat_extra", 1, 0);
            else                   check("beat_data", m_data, exp_q.pop_front());
`ifdef FIFO_RD_LAST_EN
            check("m_last", m_last, pkt_idx == PKT_LEN - 1);
            pkt_idx = (pkt_idx == PKT_LEN - 1) ? 0 : pkt_idx + 1;
`else
            check("m_last", m_last, 0);
`endif
            if (m_last) last_cnt++;
         end
         stalled_prev = m_valid & ~m_ready;
         stall_data   = m_data;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_stats();
      read_cnt = 0; beat_cnt = 0; last_cnt = 0;
      first_read = -1; first_valid = -1; first_beat = -1; last_beat = -1;
   endtask

   task automatic fifo_write(input logic [W-1:0] w);
      wr_en   = 1'b1;
      wr_data = w;
      exp_q.push_back(w);
      step(1);
      wr_en = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !m_valid && !fifo_valid) done = 1'b1;
      end
      check("drain_done", done, 1);
      step(1);
   endtask

   task automatic do_reset();
      rst = 1'b1; fifo_rst = 1'b1;
      exp_q.delete();
      pkt_idx = 0;
      step(2);
      rst = 1'b0; fifo_rst = 1'b0;
      step(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; fifo_rst = 1'b1; en = 1'b0; m_ready = 1'b0;
      wr_en = 1'b0; wr_data = '0; spur = 1'b0; rd_acc = 1'b0;
      step(3);
      rst = 1'b0; fifo_rst = 1'b0;
      step(1);
      check("rst_m_valid", m_valid, 0);
      check("rst_err", err, 0);
      check("rst_fifo_read", fifo_read, 0);
      check("rst_m_last", m_last, 0);

      // 1: streaming, latency and throughput
      clear_stats();
      en = 1'b1; m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) fifo_write(16'(i));
      wait_drain(60);
      check("t1_latency", first_valid - first_read, 2);
      check("t1_beats", beat_cnt, 8);
      check("t1_no_gap", last_beat - first_beat, 7);
      check("t1_read_low", fifo_read, 0);
      check("t1_err", err, 0);

      // 2: backpressure fills the buffer, then drains without a gap
      en = 1'b0; m_ready = 1'b0;
      for (int i = 1; i <= 8; i++) fifo_write(16'h0010 + 16'(i));
      clear_stats();
      en = 1'b1;
      step(10);
      check("t2_stall_reads", read_cnt, 2);
      check("t2_m_valid", m_valid, 1);
      check("t2_head", m_data, 16'h0011);
      check("t2_read_low", fifo_read, 0);
      m_ready = 1'b1;
      wait_drain(60);
      check("t2_beats", beat_cnt, 8);
      check("t2_no_gap", last_beat - first_beat, 7);

      // 3: alternating ready
      en = 1'b0; m_ready = 1'b0;
      for (int i = 1; i <= 8; i++) fifo_write(16'h0030 + 16'(i));
      clear_stats();
      en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         m_ready = (i % 2 == 0);
         step(1);
      end
      m_ready = 1'b1;
      wait_drain(60);
      check("t3_beats", beat_cnt, 8);
      check("t3_err", err, 0);

      // 4: en drops right after one read issues
      en = 1'b0; m_ready = 1'b1;
      for (int i = 1; i <= 4; i++) fifo_write(16'h0040 + 16'(i));
      clear_stats();
      en = 1'b1;
      step(1);
      en = 1'b0;
      step(6);
      check("t4_one_beat", beat_cnt, 1);
      check("t4_one_read", read_cnt, 1);
      check("t4_m_valid", m_valid, 0);
      check("t4_read_low", fifo_read, 0);
      en = 1'b1;
      wait_drain(60);
      check("t4_beats", beat_cnt, 4);

      // 5: reset while the buffer is full
      en = 1'b0; m_ready = 1'b0;
      for (int i = 1; i <= 4; i++) fifo_write(16'h0050 + 16'(i));
      en = 1'b1;
      step(5);
      check("t5_full_valid", m_valid, 1);
      rst = 1'b1; fifo_rst = 1'b1;
      #1;
      check("t5_async_valid", m_valid, 0);
      exp_q.delete();
      pkt_idx = 0;
      step(2);
      rst = 1'b0; fifo_rst = 1'b0;
      step(1);
      check("t5_err", err, 0);
      check("t5_valid_after", m_valid, 0);
      clear_stats();
      m_ready = 1'b1;
      fifo_write(16'h005A);
      fifo_write(16'h005B);
      fifo_write(16'h005C);
      wait_drain(60);
      check("t5_beats", beat_cnt, 3);

      // 6: packet framing and sticky error
      do_reset();
      clear_stats();
      en = 1'b1; m_ready = 1'b1;
      for (int i = 1; i <= 7; i++) fifo_write(16'h0060 + 16'(i));
      wait_drain(60);
      check("t6_beats", beat_cnt, 7);
      check("t6_lasts", last_cnt, EXP_LASTS);
      check("t6_err_clean", err, 0);
      en = 1'b0;
      step(2);
      spur = 1'b1;
      exp_q.push_back(16'h0067);
      step(1);
      spur = 1'b0;
      check("t6_err_set", err, 1);
      wait_drain(30);
      step(3);
      check("t6_err_sticky", err, 1);
      check("t6_beats_total", beat_cnt, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
